// File: rtl/seq_det_pkg.sv
// Shared constants, configuration record and width helper for the serial pattern detector.
package seq_det_pkg;

  // Storage widths for the configuration record; MAX_LEN must not exceed CFG_PAT_W.
  localparam int CFG_PAT_W = 32;
  localparam int CFG_LEN_W = 8;

  localparam int         DEF_MAX_LEN = 8;
  localparam int         DEF_CNT_W   = 8;
  localparam logic [7:0] DEF_PATTERN = 8'h01;
  localparam int         DEF_LEN     = 2;
  localparam bit         DEF_OVERLAP = 1'b1;

  function automatic int lw_f(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  typedef struct packed {
    logic [CFG_PAT_W-1:0] pattern;
    logic [CFG_LEN_W-1:0] len;
    logic                 overlap;
  } cfg_t;

endpackage

// File: rtl/seq_det_hist.sv
// Sample history shift register and fill counter; fill tracks how many valid bits are in hist.
module seq_det_hist #(
  parameter int MAX_LEN = 8,
  parameter int LW      = 4
) (
  input  logic               clk_i,
  input  logic               en_i,
  input  logic               a_i,
  input  logic               clr_i,
  output logic [MAX_LEN-1:0] hist_next_o,
  output logic [LW-1:0]      fill_next_o
);

  logic [MAX_LEN-1:0] hist_q;
  logic [LW-1:0]      fill_q;

  // Next values ignore clr so the match logic can feed clr without a loop.
  always_comb begin
    hist_next_o = hist_q;
    fill_next_o = fill_q;
    if (en_i) begin
      hist_next_o = {hist_q[MAX_LEN-2:0], a_i};
      fill_next_o = (fill_q == LW'(MAX_LEN)) ? fill_q : fill_q + LW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_next_o;
      fill_q <= fill_next_o;
    end
  end

endmodule

// File: rtl/pattern_sequence_detector.sv
// Runtime-configurable serial pattern detector with overlap control and a saturating match counter.
module pattern_sequence_detector #(
  parameter int                 MAX_LEN     = seq_det_pkg::DEF_MAX_LEN,
  parameter int                 CNT_W       = seq_det_pkg::DEF_CNT_W,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(seq_det_pkg::DEF_PATTERN),
  parameter int                 DEF_LEN     = seq_det_pkg::DEF_LEN,
  parameter bit                 DEF_OVERLAP = seq_det_pkg::DEF_OVERLAP,
  localparam int                LW          = seq_det_pkg::lw_f(MAX_LEN)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               a_i,
  input  logic               cfg_we_i,
  input  logic [MAX_LEN-1:0] cfg_pattern_i,
  input  logic [LW-1:0]      cfg_len_i,
  input  logic               cfg_overlap_i,
  input  logic               cnt_clr_i,
  output logic               y_o,
  output logic [CNT_W-1:0]   match_count_o,
  output logic               cfg_err_o
);

  import seq_det_pkg::*;

  localparam cfg_t CFG_RST = '{pattern: CFG_PAT_W'(DEF_PATTERN),
                               len:     CFG_LEN_W'(DEF_LEN),
                               overlap: DEF_OVERLAP};

  cfg_t               cfg_q, cfg_d;
  logic               y_q, y_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cfg_ok, sample, match, hist_clr;
  logic [MAX_LEN-1:0] hist_next;
  logic [LW-1:0]      fill_next;
  logic [CFG_PAT_W-1:0] mask, diff;

  assign cfg_ok = cfg_we_i && (cfg_len_i != '0) && (cfg_len_i <= LW'(MAX_LEN));
  assign sample = en_i && !cfg_we_i;

  // Only the newest len bits take part; a shift of CFG_PAT_W yields an all-ones mask.
  assign mask  = ~({CFG_PAT_W{1'b1}} << cfg_q.len);
  assign diff  = (CFG_PAT_W'(hist_next) ^ cfg_q.pattern) & mask;
  assign match = sample && (CFG_LEN_W'(fill_next) >= cfg_q.len) && (diff == '0);

  // Non-overlap restart clears history too; fill alone would suffice but this keeps it uniform.
  assign hist_clr = rst_i || cfg_ok || (match && !cfg_q.overlap);

  seq_det_hist #(
    .MAX_LEN (MAX_LEN),
    .LW      (LW)
  ) u_hist (
    .clk_i       (clk_i),
    .en_i        (sample),
    .a_i         (a_i),
    .clr_i       (hist_clr),
    .hist_next_o (hist_next),
    .fill_next_o (fill_next)
  );

  always_comb begin
    cfg_d = cfg_q;
    y_d   = match;
    err_d = cfg_we_i && !cfg_ok;
    cnt_d = cnt_q;
    if (cfg_ok) begin
      cfg_d = '{pattern: CFG_PAT_W'(cfg_pattern_i),
                len:     CFG_LEN_W'(cfg_len_i),
                overlap: cfg_overlap_i};
      cnt_d = '0;
    end else if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_q <= CFG_RST;
      y_q   <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      cfg_q <= cfg_d;
      y_q   <= y_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign y_o           = y_q;
  assign match_count_o = cnt_q;
  assign cfg_err_o     = err_q;

endmodule
